// File: rtl/board_scanner_if.sv
// Connection between the board scanner, the game FSM and the board read port.
interface board_scanner_if;
    logic       scan_start;
    logic [1:0] read_data;
    logic [5:0] scan_pos;
    logic       scan_busy;
    logic       scan_done;
    logic       p1_four_row;
    logic       p2_four_row;
    logic       tie_game;

    // Game FSM / board memory side.
    modport master (
        output scan_start, read_data,
        input  scan_pos, scan_busy, scan_done, p1_four_row, p2_four_row, tie_game
    );

    // Scanner side.
    modport slave (
        input  scan_start, read_data,
        output scan_pos, scan_busy, scan_done, p1_four_row, p2_four_row, tie_game
    );
endinterface

// File: rtl/board_scanner.sv
// Walks every vertical, horizontal and diagonal line of the 7x6 Connect 4 board
// through the read port in a fixed 144-read run and derives the game-over flags.
module board_scanner (
    input logic            clk,
    input logic            reset,
    board_scanner_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StVert, StHorz, StDiagR, StDiagL, StDone} state_e;

    state_e     state_q, state_d;
    logic [5:0] pos_q, pos_d;
    logic [2:0] line_q, line_d;       // line index within the current phase
    logic [2:0] lpos_q, lpos_d;       // cell index within the current line
    logic [1:0] owner_q, owner_d;
    logic [2:0] len_q, len_d;
    logic       full_q, full_d;
    logic       p1_q, p1_d;
    logic       p2_q, p2_d;
    logic       tie_q, tie_d;

    logic       scanning;
    logic       accept;
    logic [2:0] line_len;
    logic       line_end;
    logic       last_line;
    logic       phase_end;
    logic [5:0] next_start_r;
    logic [5:0] next_start_l;
    logic       nonempty;
    logic       extend;

    assign scanning = (state_q == StVert) || (state_q == StHorz) ||
                      (state_q == StDiagR) || (state_q == StDiagL);
    // DONE hands straight back to idle, so a start seen there is taken as the
    // idle acceptance; this gives back-to-back scans one cycle after done.
    assign accept   = bus.scan_start && ((state_q == StIdle) || (state_q == StDone));

    // Line geometry of the current phase and the start address of the next diagonal.
    always_comb begin
        line_len = 3'd6;
        case (state_q)
            StHorz:           line_len = 3'd7;
            StDiagR, StDiagL: begin
                case (line_q)
                    3'd0, 3'd5: line_len = 3'd4;
                    3'd1, 3'd4: line_len = 3'd5;
                    default:    line_len = 3'd6;
                endcase
            end
            default:          line_len = 3'd6;
        endcase
        line_end  = (lpos_q == line_len - 3'd1);
        last_line = (state_q == StVert) ? (line_q == 3'd6) : (line_q == 3'd5);
        phase_end = line_end && last_line;

        case (line_q)
            3'd0:    next_start_r = 6'd1;
            3'd1:    next_start_r = 6'd0;
            3'd2:    next_start_r = 6'd6;
            3'd3:    next_start_r = 6'd12;
            3'd4:    next_start_r = 6'd18;
            default: next_start_r = 6'd2;
        endcase
        case (line_q)
            3'd0:    next_start_l = 6'd24;
            3'd1:    next_start_l = 6'd30;
            3'd2:    next_start_l = 6'd36;
            3'd3:    next_start_l = 6'd37;
            3'd4:    next_start_l = 6'd38;
            default: next_start_l = 6'd18;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic: phases advance on the last read of their last line.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StVert;
            StVert:  if (phase_end) state_d = StHorz;
            StHorz:  if (phase_end) state_d = StDiagR;
            StDiagR: if (phase_end) state_d = StDiagL;
            StDiagL: if (phase_end) state_d = StDone;
            StDone:  state_d = accept ? StVert : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode of the state register.
    always_comb begin
        bus.scan_busy = scanning;
        bus.scan_done = (state_q == StDone);
    end

    assign bus.scan_pos    = pos_q;
    assign bus.p1_four_row = p1_q;
    assign bus.p2_four_row = p2_q;
    assign bus.tie_game    = tie_q;

    // Datapath next state: address walk, run tracking and flag updates.
    always_comb begin
        pos_d    = pos_q;
        line_d   = line_q;
        lpos_d   = lpos_q;
        owner_d  = owner_q;
        len_d    = len_q;
        full_d   = full_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        tie_d    = tie_q;
        nonempty = (bus.read_data == 2'b01) || (bus.read_data == 2'b10);
        extend   = (lpos_q != 3'd0) && nonempty && (bus.read_data == owner_q);

        if (accept) begin
            pos_d   = 6'd0;
            line_d  = 3'd0;
            lpos_d  = 3'd0;
            owner_d = 2'b00;
            len_d   = 3'd0;
            full_d  = 1'b1;
            p1_d    = 1'b0;
            p2_d    = 1'b0;
            tie_d   = 1'b0;
        end else if (scanning) begin
            owner_d = bus.read_data;
            if (extend) len_d = (len_q == 3'd4) ? 3'd4 : len_q + 3'd1;
            else        len_d = {2'b00, nonempty};
            if (len_d == 3'd4) begin
                if (bus.read_data == 2'b01) p1_d = 1'b1;
                if (bus.read_data == 2'b10) p2_d = 1'b1;
            end
            if ((state_q == StVert) && !nonempty) full_d = 1'b0;

            if (line_end) begin
                lpos_d = 3'd0;
                line_d = last_line ? 3'd0 : line_q + 3'd1;
            end else begin
                lpos_d = lpos_q + 3'd1;
            end

            case (state_q)
                StVert:  pos_d = phase_end ? 6'd0 : pos_q + 6'd1;
                StHorz:  begin
                    if (phase_end)     pos_d = 6'd2;
                    else if (line_end) pos_d = {3'b000, line_q + 3'd1};
                    else               pos_d = pos_q + 6'd6;
                end
                StDiagR: begin
                    if (phase_end)     pos_d = 6'd18;
                    else if (line_end) pos_d = next_start_r;
                    else               pos_d = pos_q + 6'd7;
                end
                StDiagL: begin
                    if (phase_end)     pos_d = pos_q;
                    else if (line_end) pos_d = next_start_l;
                    else               pos_d = pos_q - 6'd5;
                end
                default: pos_d = pos_q;
            endcase

            if ((state_q == StDiagL) && phase_end) tie_d = full_q && !p1_d && !p2_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q   <= 6'd0;
            line_q  <= 3'd0;
            lpos_q  <= 3'd0;
            owner_q <= 2'b00;
            len_q   <= 3'd0;
            full_q  <= 1'b0;
            p1_q    <= 1'b0;
            p2_q    <= 1'b0;
            tie_q   <= 1'b0;
        end else begin
            pos_q   <= pos_d;
            line_q  <= line_d;
            lpos_q  <= lpos_d;
            owner_q <= owner_d;
            len_q   <= len_d;
            full_q  <= full_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            tie_q   <= tie_d;
        end
    end

endmodule

// File: tb/tb_board_scanner.sv
// Bench for board_scanner: directed board table, handshake/reset sequences and
// random boards checked against a line-search reference model.
module tb_board_scanner;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    board_scanner_if bus ();

    board_scanner dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [1:0] board [0:63];
    assign bus.read_data = board[bus.scan_pos];

    int errors = 0;
    int checks = 0;
    int addr_seq[$];

    typedef struct {
        string       name;
        bit          draw;
        logic [1:0]  val;
        logic [41:0] mask;
        bit          clr41;
        bit          p1;
        bit          p2;
        bit          tie;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [41:0] bits4(input int a, input int b, input int c, input int d);
        logic [41:0] m;
        m = '0;
        m[a] = 1'b1;
        m[b] = 1'b1;
        m[c] = 1'b1;
        m[d] = 1'b1;
        return m;
    endfunction

    // Scan order built from board geometry: columns, rows, then both diagonal families.
    task automatic build_addr_seq();
        int rs[6];
        int cs[6];
        int ls[6];
        addr_seq.delete();
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++) addr_seq.push_back(c * 6 + r);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++) addr_seq.push_back(c * 6 + r);
        cs = '{0, 0, 0, 1, 2, 3};
        rs = '{2, 1, 0, 0, 0, 0};
        ls = '{4, 5, 6, 6, 5, 4};
        for (int l = 0; l < 6; l++)
            for (int i = 0; i < ls[l]; i++) addr_seq.push_back((cs[l] + i) * 6 + rs[l] + i);
        cs = '{3, 4, 5, 6, 6, 6};
        rs = '{0, 0, 0, 0, 1, 2};
        for (int l = 0; l < 6; l++)
            for (int i = 0; i < ls[l]; i++) addr_seq.push_back((cs[l] - i) * 6 + rs[l] + i);
    endtask

    // Reference: any four equal cells along any of the four directions.
    function automatic bit has_four(input logic [1:0] who);
        int dc[4];
        int dr[4];
        bit ok;
        int cc;
        int rr;
        dc = '{0, 1, 1, -1};
        dr = '{1, 0, 1, 1};
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++)
                for (int d = 0; d < 4; d++) begin
                    ok = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        cc = c + k * dc[d];
                        rr = r + k * dr[d];
                        if (cc < 0 || cc > 6 || rr > 5) ok = 1'b0;
                        else if (board[cc * 6 + rr] != who) ok = 1'b0;
                    end
                    if (ok) return 1'b1;
                end
        return 1'b0;
    endfunction

    function automatic bit is_full();
        for (int a = 0; a < 42; a++)
            if (board[a] != 2'b01 && board[a] != 2'b10) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_board();
        for (int a = 0; a < 64; a++) board[a] = 2'b00;
    endtask

    task automatic load_vec(input vec_t v);
        clear_board();
        if (v.draw)
            for (int c = 0; c < 7; c++)
                for (int r = 0; r < 6; r++)
                    board[c * 6 + r] = (((r + 2 * c) & 2) == 0) ? 2'b01 : 2'b10;
        for (int a = 0; a < 42; a++) if (v.mask[a]) board[a] = v.val;
        if (v.clr41) board[41] = 2'b00;
    endtask

    // One full scan from an idle DUT: address walk, busy/done timing and final flags.
    task automatic run_scan(input string name, input bit e1, input bit e2, input bit et);
        int bad;
        bad = 0;
        @(negedge clk);
        bus.scan_start = 1'b1;
        @(posedge clk);
        #1 bus.scan_start = 1'b0;
        for (int n = 0; n < 144; n++) begin
            if (bus.scan_pos !== 6'(addr_seq[n]) || bus.scan_busy !== 1'b1 ||
                bus.scan_done !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        check($sformatf("%s walk_errs", name), bad, 0);
        check($sformatf("%s done", name), bus.scan_done, 1);
        check($sformatf("%s busy_off", name), bus.scan_busy, 0);
        check($sformatf("%s p1", name), bus.p1_four_row, e1);
        check($sformatf("%s p2", name), bus.p2_four_row, e2);
        check($sformatf("%s tie", name), bus.tie_game, et);
        @(posedge clk);
        #1;
        check($sformatf("%s done_drop", name), bus.scan_done, 0);
        check($sformatf("%s flags_hold", name),
              {bus.p1_four_row, bus.p2_four_row, bus.tie_game}, {e1, e2, et});
    endtask

    initial begin
        int  done_edges[$];
        bit  busy145;
        int  mode;
        bit  m1;
        bit  m2;

        bus.scan_start = 1'b0;
        reset = 1'b1;
        clear_board();
        build_addr_seq();

        vecs[0] = '{"empty",      0, 2'b00, '0,                   0, 0, 0, 0};
        vecs[1] = '{"vert_p1",    0, 2'b01, bits4(0, 1, 2, 3),     0, 1, 0, 0};
        vecs[2] = '{"vert_split", 0, 2'b10, bits4(4, 5, 6, 7),     0, 0, 0, 0};
        vecs[3] = '{"horz_p2",    0, 2'b10, bits4(18, 24, 30, 36), 0, 0, 1, 0};
        vecs[4] = '{"diagr_p1",   0, 2'b01, bits4(2, 9, 16, 23),   0, 1, 0, 0};
        vecs[5] = '{"diagl_p2",   0, 2'b10, bits4(36, 31, 26, 21), 0, 0, 1, 0};
        vecs[6] = '{"draw",       1, 2'b00, '0,                   0, 0, 0, 1};
        vecs[7] = '{"draw_hole",  1, 2'b00, '0,                   1, 0, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst scan_pos", bus.scan_pos, 0);
        check("rst busy", bus.scan_busy, 0);
        check("rst done", bus.scan_done, 0);
        check("rst flags", {bus.p1_four_row, bus.p2_four_row, bus.tie_game}, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            load_vec(vecs[i]);
            run_scan(vecs[i].name, vecs[i].p1, vecs[i].p2, vecs[i].tie);
        end

        // Start held high: second acceptance one cycle after the done pulse.
        clear_board();
        @(negedge clk);
        bus.scan_start = 1'b1;
        @(posedge clk);
        busy145 = 1'b0;
        for (int e = 1; e <= 300; e++) begin
            @(posedge clk);
            #1;
            if (bus.scan_done) done_edges.push_back(e);
            if (e == 145) busy145 = bus.scan_busy;
            if (e == 289) bus.scan_start = 1'b0;
        end
        check("held done_count", done_edges.size(), 2);
        check("held done0", (done_edges.size() > 0) ? done_edges[0] : -1, 144);
        check("held done1", (done_edges.size() > 1) ? done_edges[1] : -1, 289);
        check("held busy145", busy145, 1);

        // Start pulse in the middle of a scan is dropped.
        load_vec(vecs[1]);
        done_edges.delete();
        @(negedge clk);
        bus.scan_start = 1'b1;
        @(posedge clk);
        #1 bus.scan_start = 1'b0;
        for (int e = 1; e <= 300; e++) begin
            @(posedge clk);
            #1;
            if (bus.scan_done) done_edges.push_back(e);
            if (e == 49) bus.scan_start = 1'b1;
            if (e == 50) bus.scan_start = 1'b0;
        end
        check("midstart done_count", done_edges.size(), 1);
        check("midstart done0", (done_edges.size() > 0) ? done_edges[0] : -1, 144);
        check("midstart p1", bus.p1_four_row, 1);

        // Reset at edge 70 aborts without a done pulse; a restart still finds the win.
        done_edges.delete();
        @(negedge clk);
        bus.scan_start = 1'b1;
        @(posedge clk);
        #1 bus.scan_start = 1'b0;
        for (int e = 1; e <= 200; e++) begin
            @(posedge clk);
            #1;
            if (bus.scan_done) done_edges.push_back(e);
            if (e == 69) reset = 1'b1;
            if (e == 70) begin
                check("rstmid busy", bus.scan_busy, 0);
                check("rstmid pos", bus.scan_pos, 0);
                check("rstmid flags", {bus.p1_four_row, bus.p2_four_row, bus.tie_game}, 0);
                reset = 1'b0;
            end
        end
        check("rstmid no_done", done_edges.size(), 0);
        run_scan("restart", 1'b1, 1'b0, 1'b0);

        // Random boards against the reference model.
        for (int t = 0; t < 24; t++) begin
            mode = t % 3;
            clear_board();
            for (int a = 0; a < 42; a++) begin
                case (mode)
                    0: board[a] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                    1: board[a] = 2'($urandom_range(0, 3));
                    default: board[a] = 2'($urandom_range(1, 2));
                endcase
            end
            m1 = has_four(2'b01);
            m2 = has_four(2'b10);
            run_scan($sformatf("rnd%0d", t), m1, m2, is_full() && !m1 && !m2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
